load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential data-memory access unit for the MIPS datapath, replacing the combinational byte-only load path with a handshaked, multi-cycle unit. It accepts one load or store per transaction and supports byte, halfword and word sizes with sign or zero extension. It generates word-aligned memory requests with byte enables, detects misalignment, times out on an unresponsive memory, and returns a registered result to the core.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- TIMEOUT_CYCLES, 255, maximum cycles mem_req may stay high without mem_ready (≥1)

Ports:
- CLK  input  1  clock
- RESET  input  1  asynchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  unit can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned access, reserved size, or timeout
- mem_req  output  1  memory access strobe
- mem_we  output  1  write enable
- mem_be  output  4  byte lane enables
- mem_addr  output  ADDR_WIDTH  word address; bits [1:0] always 0
- mem_wdata  output  32  lane-replicated store data
- mem_ready  input  1  memory completes access this cycle
- mem_rdata  input  32  read word, valid when mem_ready is high

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches all req_* fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 3 goes directly to RESP with error=1. No mem_req is issued.
  - Any other request goes to ACCESS.
- ACCESS: mem_req=1, and all mem_* outputs stay stable until mem_ready.
  - Lanes are little-endian: lane = addr[1:0].
  - mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
  - mem_wdata: byte replicated 4×, half replicated 2×, word as-is.
  - On mem_ready: loads extract the addressed lane(s), then extend to 32 bits as selected by req_unsigned and latch into resp_rdata. Next state is RESP.
- Timeout: a counter clears on entry to ACCESS and increments each cycle without mem_ready. When it reaches TIMEOUT_CYCLES-1 with no mem_ready, mem_req drops and the state goes to RESP with error=1 and rdata=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_error hold their values until the next response.
- mem_rdata is ignored outside ACCESS, and mem_ready outside ACCESS has no effect.

## Timing
- Reset values: state IDLE; req_ready 0; resp_valid 0; resp_rdata 0; resp_error 0; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0; timeout counter 0.
- req_ready goes to 1 on the first CLK edge after RESET deasserts. It is registered and is 1 only in IDLE.
- Handshake at edge N, memory path: mem_req is high in cycle N+1. If mem_ready is high in N+1, resp_valid is high in N+2. Minimum latency is 2 cycles, and each extra memory wait cycle adds 1.
- Handshake at edge N, error path: resp_valid is high in cycle N+1.
- A new request can be accepted in the cycle after resp_valid. Back-to-back throughput is one access per 3 cycles.
- mem_ready and the timeout limit in the same cycle: mem_ready wins, and the access completes without error.
- RESET asserted mid-ACCESS: mem_req drops immediately (asynchronously), any pending response is discarded, and no resp_valid is produced.

## Structure
- Package lsu_pkg holds:
  - typedef enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}
  - typedef enum state_t {IDLE, ACCESS, RESP}
  - function byte_enable(size, addr_lo)
  - function misaligned(size, addr_lo)
- Sub-module lsu_extend (combinational) takes word, addr_lo, size and is_unsigned, and produces the 32-bit result. It is the generalised successor of the byte-load extend path.
- The top level holds the FSM, request registers, timeout counter and output registers.

## Test plan
- Load byte, signed, addr 0x1003, mem_rdata 0x80FF_1234, mem_ready in first ACCESS cycle -> mem_addr 0x1000, mem_be 1000; resp_rdata 0xFFFF_FF80 two cycles after handshake; error 0.
- Load half, unsigned, addr 0x2002, mem_rdata 0xBEEF_0000 after 3 wait cycles -> resp_rdata 0x0000_BEEF; resp_valid 5 cycles after handshake.
- Store byte 0x0000_00A5 to addr 0x31 -> mem_we 1, mem_addr 0x30, mem_be 0010, mem_wdata 0xA5A5_A5A5; resp_rdata 0, error 0.
- Load word at addr 0x6, then size 3 at addr 0x0 -> each yields resp_valid with error 1 one cycle after its handshake; mem_req never asserted.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high exactly 4 cycles; resp_error 1, resp_rdata 0.
- RESET pulsed during ACCESS -> mem_req 0 immediately; no resp_valid; req_ready 1 one edge after RESET deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Little-endian lane numbering: lane = byte address [1:0].
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [3:0] byte_enable(
        input size_t      size,
        input logic [1:0] addr_lo
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(
        input size_t      size,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Load data lane extraction and sign/zero extension.
// Generalises the old byte-only load extend path to half and word.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane(s) and extend to 32 bits.
    always_comb begin
        lane_b = word[7:0];
        lane_h = word[15:0];
        result = '0;
        case (addr_lo)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        if (addr_lo[1]) begin
            lane_h = word[31:16];
        end
        case (size)
            SZ_BYTE: result = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
            SZ_HALF: result = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
            SZ_WORD: result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked multi-cycle load/store unit: IDLE -> ACCESS -> RESP.
// All core and memory facing outputs come straight from flops.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_error_q, resp_error_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    size_t                   size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              lo_q, lo_d;

    size_t       in_size;
    logic        fire;
    logic        bad_req;
    logic [31:0] rep_wdata;
    logic [31:0] ext_data;

    assign in_size = size_t'(req_size);
    assign fire    = req_valid & req_ready_q;
    assign bad_req = (in_size == SZ_RSVD)
                   | misaligned(in_size, req_addr[1:0]);

    lsu_extend u_extend (
        .word        (mem_rdata),
        .addr_lo     (lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    // Replicate right-justified store data across the lanes it may hit.
    always_comb begin
        rep_wdata = req_wdata;
        case (in_size)
            SZ_BYTE: rep_wdata = {4{req_wdata[7:0]}};
            SZ_HALF: rep_wdata = {2{req_wdata[15:0]}};
            default: rep_wdata = req_wdata;
        endcase
    end

    // Next-state, request capture, timeout and response computation.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lo_d         = lo_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    wr_d   = req_write;
                    size_d = in_size;
                    uns_d  = req_unsigned;
                    lo_d   = req_addr[1:0];
                    if (bad_req) begin
                        state_d      = RESP;
                        resp_rdata_d = '0;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_we_d    = req_write;
                        mem_be_d    = byte_enable(in_size, req_addr[1:0]);
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = rep_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d      = RESP;
                    resp_rdata_d = wr_q ? 32'd0 : ext_data;
                    resp_error_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d      = RESP;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d  = (state_d == IDLE);
        mem_req_d    = (state_d == ACCESS);
        resp_valid_d = (state_d == RESP);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lo_q         <= lo_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Runs with a 4-cycle memory timeout.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_valid;
    logic        o_stable;
    int          o_lat;
    int          o_req_cycles;
    int          o_hs_cyc;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    load_store_unit #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    // One full transaction; memory answers after 'waits' stalled cycles.
    task automatic run_mem(
        input logic        w,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          waits
    );
        int left;
        int guard;
        left         = waits;
        guard        = 0;
        o_valid      = 1'b0;
        o_stable     = 1'b1;
        o_req_cycles = 0;
        o_lat        = 0;
        while (!req_ready && guard < 20) begin
            @(posedge CLK); #1;
            guard++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge CLK); #1;
        o_hs_cyc  = cyc;
        req_valid = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        req_addr  = 32'hFFFF_FFFF;
        o_lat     = 1;
        o_we      = mem_we;
        o_be      = mem_be;
        o_addr    = mem_addr;
        o_wdata   = mem_wdata;
        while (!resp_valid && o_lat < 40) begin
            if (mem_req) begin
                o_req_cycles++;
                if (mem_we !== o_we || mem_be !== o_be ||
                    mem_addr !== o_addr || mem_wdata !== o_wdata)
                    o_stable = 1'b0;
                if (left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end else begin
                    left--;
                    mem_rdata = $urandom;
                end
            end
            @(posedge CLK); #1;
            mem_ready = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            o_lat++;
        end
        o_valid = resp_valid;
        o_rdata = resp_rdata;
        o_err   = resp_error;
    endtask

    task automatic test_reset;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_ready: got %b want 0", req_ready);
        end
        n_checks++;
        if ({resp_valid, resp_error, mem_req, mem_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_flags: got %b want 0000",
                     {resp_valid, resp_error, mem_req, mem_we});
        end
        n_checks++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin
            n_fail++;
            $display("FAIL rst_data: got %h %h %h %h want zeros",
                     resp_rdata, mem_addr, mem_wdata, mem_be);
        end
        RESET = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready_early: got %b want 0", req_ready);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready_rise: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load_byte;
        run_mem(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        n_checks++;
        if (o_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL lb_addr: got %h want 00001000", o_addr);
        end
        n_checks++;
        if (o_be !== 4'b1000 || o_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_be_we: got %b/%b want 1000/0", o_be, o_we);
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_lat != 2) begin
            n_fail++;
            $display("FAIL lb_latency: got v=%b lat=%0d want v=1 lat=2",
                     o_valid, o_lat);
        end
        n_checks++;
        if (o_rdata !== 32'hFFFF_FF80 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_rdata: got %h err=%b want ffffff80 err=0",
                     o_rdata, o_err);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_hold: got v=%b d=%h want v=0 d=ffffff80",
                     resp_valid, resp_rdata);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_ready_after: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load_half_wait;
        run_mem(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'hBEEF_0000, 3);
        n_checks++;
        if (o_rdata !== 32'h0000_BEEF || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_rdata: got %h err=%b want 0000beef err=0",
                     o_rdata, o_err);
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_lat != 5) begin
            n_fail++;
            $display("FAIL lh_latency: got v=%b lat=%0d want v=1 lat=5",
                     o_valid, o_lat);
        end
        n_checks++;
        if (o_be !== 4'b1100 || o_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL lh_be_addr: got %b %h want 1100 00002000",
                     o_be, o_addr);
        end
        n_checks++;
        if (o_stable !== 1'b1 || o_req_cycles != 4) begin
            n_fail++;
            $display("FAIL lh_req_hold: got stable=%b cyc=%0d want 1 4",
                     o_stable, o_req_cycles);
        end
    endtask

    task automatic test_store;
        run_mem(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_00A5, 32'h1111_1111, 0);
        n_checks++;
        if (o_we !== 1'b1 || o_addr !== 32'h30 || o_be !== 4'b0010) begin
            n_fail++;
            $display("FAIL sb_ctl: got we=%b a=%h be=%b want 1 00000030 0010",
                     o_we, o_addr, o_be);
        end
        n_checks++;
        if (o_wdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata);
        end
        n_checks++;
        if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_lat != 2) begin
            n_fail++;
            $display("FAIL sb_resp: got %h err=%b lat=%0d want 0 0 2",
                     o_rdata, o_err, o_lat);
        end
        run_mem(1'b1, 2'd1, 1'b0, 32'h42, 32'h1234_ABCD, 32'h0, 1);
        n_checks++;
        if (o_wdata !== 32'hABCD_ABCD || o_be !== 4'b1100 ||
            o_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL sh_ctl: got %h %b %h want abcdabcd 1100 00000040",
                     o_wdata, o_be, o_addr);
        end
        run_mem(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFE_F00D, 32'h0, 0);
        n_checks++;
        if (o_wdata !== 32'hCAFE_F00D || o_be !== 4'b1111 ||
            o_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL sw_ctl: got %h %b %h want cafef00d 1111 00000008",
                     o_wdata, o_be, o_addr);
        end
    endtask

    task automatic test_extend;
        run_mem(1'b0, 2'd1, 1'b0, 32'h2000, 32'h0, 32'h0000_8001, 0);
        n_checks++;
        if (o_rdata !== 32'hFFFF_8001 || o_be !== 4'b0011) begin
            n_fail++;
            $display("FAIL lhs_rdata: got %h be=%b want ffff8001 0011",
                     o_rdata, o_be);
        end
        run_mem(1'b0, 2'd0, 1'b1, 32'h1002, 32'h0, 32'h00F0_0000, 0);
        n_checks++;
        if (o_rdata !== 32'h0000_00F0 || o_be !== 4'b0100) begin
            n_fail++;
            $display("FAIL lbu_rdata: got %h be=%b want 000000f0 0100",
                     o_rdata, o_be);
        end
        run_mem(1'b0, 2'd2, 1'b0, 32'h2004, 32'h0, 32'h1234_5678, 2);
        n_checks++;
        if (o_rdata !== 32'h1234_5678 || o_be !== 4'b1111 ||
            o_addr !== 32'h2004) begin
            n_fail++;
            $display("FAIL lw_rdata: got %h be=%b a=%h want 12345678 1111 2004",
                     o_rdata, o_be, o_addr);
        end
    endtask

    task automatic test_timeout;
        run_mem(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h5555_5555, 100);
        n_checks++;
        if (o_req_cycles != TO) begin
            n_fail++;
            $display("FAIL to_req_cycles: got %0d want %0d", o_req_cycles, TO);
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_resp: got v=%b err=%b d=%h want 1 1 0",
                     o_valid, o_err, o_rdata);
        end
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_req_drop: got %b want 0", mem_req);
        end
    endtask

    task automatic test_errors;
        run_mem(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 32'h0000_7700, 0);
        run_mem(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 0);
        n_checks++;
        if (o_lat != 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL err_lw: got lat=%0d err=%b d=%h want 1 1 0",
                     o_lat, o_err, o_rdata);
        end
        n_checks++;
        if (o_req_cycles != 0) begin
            n_fail++;
            $display("FAIL err_lw_noreq: got %0d want 0", o_req_cycles);
        end
        run_mem(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        n_checks++;
        if (o_lat != 1 || o_err !== 1'b1 || o_req_cycles != 0) begin
            n_fail++;
            $display("FAIL err_rsvd: got lat=%0d err=%b req=%0d want 1 1 0",
                     o_lat, o_err, o_req_cycles);
        end
        run_mem(1'b1, 2'd1, 1'b0, 32'h3, 32'h0, 32'h0, 0);
        n_checks++;
        if (o_lat != 1 || o_err !== 1'b1 || o_req_cycles != 0) begin
            n_fail++;
            $display("FAIL err_sh: got lat=%0d err=%b req=%0d want 1 1 0",
                     o_lat, o_err, o_req_cycles);
        end
        run_mem(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 32'h0000_7700, 0);
        n_checks++;
        if (o_err !== 1'b0 || o_rdata !== 32'h0000_0077) begin
            n_fail++;
            $display("FAIL err_recover: got err=%b d=%h want 0 00000077",
                     o_err, o_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int h1;
        run_mem(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0000_007F, 0);
        h1 = o_hs_cyc;
        run_mem(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hC001_0000, 0);
        n_checks++;
        if (o_hs_cyc - h1 != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want 3", o_hs_cyc - h1);
        end
        n_checks++;
        if (o_rdata !== 32'hFFFF_C001) begin
            n_fail++;
            $display("FAIL b2b_rdata: got %h want ffffc001", o_rdata);
        end
    endtask

    task automatic test_reset_mid_access;
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge CLK); #1;
            guard++;
        end
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h400;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_req_before: got %b want 1", mem_req);
        end
        #2;
        RESET     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async: got req=%b rdy=%b want 0 0",
                     mem_req, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (resp_valid !== 1'b0) seen++;
        end
        RESET     = 1'b0;
        mem_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_ready_early: got %b want 0", req_ready);
        end
        @(posedge CLK); #1;
        if (resp_valid !== 1'b0) seen++;
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rm_no_resp: got %0d pulses want 0", seen);
        end
        n_checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_after: got rdy=%b req=%b want 1 0",
                     req_ready, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_wait();
        test_store();
        test_extend();
        test_timeout();
        test_errors();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
